rv_gpio: RTL and testbench
==========================

# rv_gpio

Parametrised general-purpose I/O peripheral for the rv_core SoC, succeeding the fixed 8-bit pout/pin latch at 0xffff0000. Provides NCH banks of WIDTH pins, each with output data, per-pin direction, set/clear write aliases, a synchronised input view and latched rising/falling-edge interrupts. It sits on the rv_core data bus beside rv_sio and is selected by an address-decoded chip select.

## Interface
- NCH, 2, number of banks; legal range 1..8.
- WIDTH, 8, pins per bank; legal range 1..32.
- SYNC_STAGES, 2, input synchroniser depth; minimum 2.
- clk  in  1  system clock; all logic on the rising edge.
- xreset  in  1  asynchronous, active-low reset.
- cs  in  1  block select, decoded externally.
- adr  in  8  byte address. adr[7:5] selects the bank; adr[4:2] selects the register; adr[1:0] is ignored.
- we  in  4  byte-lane write enables; we[0] maps to dw[7:0].
- re  in  1  read enable.
- dw  in  32  write data.
- dr  out  32  registered read data.
- pin  in  NCH*WIDTH  pad inputs, asynchronous. Bank b occupies bits [b*WIDTH +: WIDTH].
- pout  out  NCH*WIDTH  output data register.
- poe  out  NCH*WIDTH  output enable; 1 = drive. Equals the DIR register.
- irq  out  1  OR of all STAT bits across all banks.

## Operation
Register map within each bank, selected by adr[4:2]:
- 0 OUT: read/write.
- 1 IN: read-only; returns the synchronised pin value.
- 2 DIR: read/write.
- 3 SET: write-only. OUT |= data.
- 4 CLR: write-only. OUT &= ~data.
- 5 RISE_EN: read/write.
- 6 FALL_EN: read/write.
- 7 STAT: read; write-1-to-clear.

Write rules:
- A write occurs when cs=1 and we!=0.
- Each write is byte-lane masked by we; bits outside the enabled lanes are unchanged.
- Bits at or above WIDTH are ignored on write and read as 0.
- Reads of the SET and CLR addresses return 0. Writes to IN are ignored.
- For a bank index >= NCH, writes have no effect and reads return 0.

Input path:
- Each pin passes through a SYNC_STAGES-deep flop chain. A further flop holds the previous synchronised value, prev.
- rise = sync & ~prev; fall = ~sync & prev.
- STAT bit i is set when (rise_i & RISE_EN_i) | (fall_i & FALL_EN_i).
- Edges are detected regardless of DIR, so output pins loop back.
- Clearing an enable bit does not clear a STAT bit that is already set.
- irq = |STAT across all banks. It is combinational from the registers, with no other logic.

Reset: xreset low clears the following asynchronously to 0: OUT, DIR, RISE_EN, FALL_EN, STAT, all synchroniser flops, prev, dr. As a result pout=0, poe=0 and irq=0.

## Timing
- Writes: a register updates on the clock edge at which cs & we is sampled. pout and poe reflect the new value in the next cycle.
- Reads: when cs & re is sampled at edge k, dr holds the selected register from edge k until edge k+1. In any other cycle dr is registered to 0. Read latency is 1 cycle; there is no wait state.
- A read returns the register value from before any write in the same cycle.
- Input latency: after a pin transition is first sampled at edge 0:
  - The IN register reflects it after edge SYNC_STAGES-1, so a read issued at that edge shows it.
  - The STAT bit and irq rise after edge SYNC_STAGES.
- If a STAT write-1-to-clear and a new qualifying edge hit the same bit in the same cycle, set wins and the bit stays 1.
- If SET and CLR for the same bit are written on different cycles, they apply in order. They cannot collide, because only one address is accessed per cycle.
- On exit from reset:
  - A pin held high propagates through the synchroniser and produces one rise event.
  - That event latches STAT only if RISE_EN is already set, which is impossible immediately after reset.
- Asserting xreset mid-operation drops pout, poe and irq to 0 without waiting for a clock edge.

## Test plan
- Reset with NCH=2, WIDTH=8 -> pout=0, poe=0, irq=0, dr=0. Reads of all 16 registers return 0.
- Sequence: write OUT bank0=0xA5; SET 0x0F; CLR 0x81; write DIR=0xFF with we=4'b0001 -> pout[7:0]=0xA5, then 0xAF, then 0x2E; poe[7:0]=0xFF. A read of OUT returns 0x0000002E one cycle after re.
- Bank1: RISE_EN=0x01. Drive pin[8] 0->1 -> IN bank1 bit0=1 visible after 2 edges; irq=1 after edge 2; STAT bank1=0x01. Write STAT=0x01 -> irq=0.
- Bank0: FALL_EN=0x80, pin[7] high. Drop pin[7] and schedule a STAT W1C of 0x80 on the cycle the STAT bit would set -> STAT bit 7 remains 1 and irq stays 1.
- WIDTH=5 build: write OUT=0xFFFFFFFF -> pout=0x1F; a read returns 0x0000001F. Access bank index 3 with NCH=2 -> the write is ignored and the read returns 0.
- Pull xreset low mid-pattern with pout=0xFF and irq=1 -> both drop to 0 before the next clk edge. STAT reads 0 after release.

Source files
------------

// File: rtl/rv_gpio_if.sv
// rv_core data-bus port of the GPIO block.
// The master drives the select, address, lanes and strobes; the slave returns registered read data.
interface rv_gpio_if;
    logic        cs;
    logic [7:0]  adr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] dw;
    logic [31:0] dr;

    modport master (output cs, adr, we, re, dw, input dr);
    modport slave  (input cs, adr, we, re, dw, output dr);
endinterface

// File: rtl/rv_gpio.sv
// Banked GPIO: OUT/DIR/SET/CLR registers, synchronised inputs, latched edge interrupts.
// Latency: writes take effect on the sampling edge; reads return data one cycle after re.
// Backpressure: none; every access completes in one cycle with no wait state.
module rv_gpio #(
    parameter int NCH         = 2,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 xreset,
    rv_gpio_if.slave             bus,
    input  logic [NCH*WIDTH-1:0] pin,
    output logic [NCH*WIDTH-1:0] pout,
    output logic [NCH*WIDTH-1:0] poe,
    output logic                 irq
);

    localparam int BW = NCH * WIDTH;

    typedef enum logic [2:0] {
        R_OUT  = 3'd0,
        R_IN   = 3'd1,
        R_DIR  = 3'd2,
        R_SET  = 3'd3,
        R_CLR  = 3'd4,
        R_RISE = 3'd5,
        R_FALL = 3'd6,
        R_STAT = 3'd7
    } reg_e;

    logic [NCH-1:0][WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, stat_q;
    logic [NCH-1:0][WIDTH-1:0] out_d, dir_d, rise_en_d, fall_en_d, stat_d;
    logic [NCH-1:0][WIDTH-1:0] in_v, prev_q, evt;
    logic [SYNC_STAGES-1:0][BW-1:0] sync_q;
    logic [31:0] dr_q, rdata;

    logic        wr, rd;
    logic [2:0]  bsel;
    reg_e        rsel;
    logic [31:0] lane_m;
    logic [WIDTH-1:0] wmask, wbits;
    logic        unused_bits;

    assign wr     = bus.cs & (|bus.we);
    assign rd     = bus.cs & bus.re;
    assign bsel   = bus.adr[7:5];
    assign rsel   = reg_e'(bus.adr[4:2]);
    assign lane_m = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
    assign wmask  = lane_m[WIDTH-1:0];
    assign wbits  = bus.dw[WIDTH-1:0] & wmask;
    assign unused_bits = ^{bus.adr[1:0], bus.dw, lane_m};

    // Edge detection runs on the synchronised view regardless of direction, so driven pins loop back.
    assign in_v = sync_q[SYNC_STAGES-1];
    assign evt  = (in_v & ~prev_q & rise_en_q) | (~in_v & prev_q & fall_en_q);

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        stat_d    = stat_q | evt;
        for (int b = 0; b < NCH; b++) begin
            if (wr && bsel == 3'(b)) begin
                case (rsel)
                    R_OUT:  out_d[b]     = (out_q[b] & ~wmask) | wbits;
                    R_SET:  out_d[b]     = out_q[b] | wbits;
                    R_CLR:  out_d[b]     = out_q[b] & ~wbits;
                    R_DIR:  dir_d[b]     = (dir_q[b] & ~wmask) | wbits;
                    R_RISE: rise_en_d[b] = (rise_en_q[b] & ~wmask) | wbits;
                    R_FALL: fall_en_d[b] = (fall_en_q[b] & ~wmask) | wbits;
                    // A fresh event in the clearing cycle survives the clear.
                    R_STAT: stat_d[b]    = (stat_q[b] & ~wbits) | evt[b];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int b = 0; b < NCH; b++) begin
            if (bsel == 3'(b)) begin
                case (rsel)
                    R_OUT:  rdata = 32'(out_q[b]);
                    R_IN:   rdata = 32'(in_v[b]);
                    R_DIR:  rdata = 32'(dir_q[b]);
                    R_RISE: rdata = 32'(rise_en_q[b]);
                    R_FALL: rdata = 32'(fall_en_q[b]);
                    R_STAT: rdata = 32'(stat_q[b]);
                    default: rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            sync_q    <= '0;
            prev_q    <= '0;
            dr_q      <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q    <= in_v;
            dr_q      <= rd ? rdata : 32'd0;
        end
    end

    assign bus.dr = dr_q;
    assign pout   = out_q;
    assign poe    = dir_q;
    assign irq    = |stat_q;

endmodule

// File: tb/tb_rv_gpio.sv
// Directed bench for rv_gpio: a register-access vector table plus hand-timed edge, collision and reset sequences.
module tb_rv_gpio;

    logic        clk = 1'b0;
    logic        xreset = 1'b0;
    logic [15:0] pin0 = '0, pout0, poe0;
    logic [9:0]  pin1 = '0, pout1, poe1;
    logic        irq0, irq1;

    rv_gpio_if b0 ();
    rv_gpio_if b1 ();

    rv_gpio #(.NCH(2), .WIDTH(8), .SYNC_STAGES(2)) u0 (
        .clk(clk), .xreset(xreset), .bus(b0.slave),
        .pin(pin0), .pout(pout0), .poe(poe0), .irq(irq0));

    rv_gpio #(.NCH(2), .WIDTH(5), .SYNC_STAGES(2)) u1 (
        .clk(clk), .xreset(xreset), .bus(b1.slave),
        .pin(pin1), .pout(pout1), .poe(poe1), .irq(irq1));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  adr;
        logic [3:0]  we;
        logic [31:0] dw;
        logic [15:0] exp_pout;
        logic [15:0] exp_poe;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        b0.cs = 0; b0.re = 0; b0.we = 0; b0.adr = 0; b0.dw = 0;
        b1.cs = 0; b1.re = 0; b1.we = 0; b1.adr = 0; b1.dw = 0;
    endtask

    task automatic bus_wr(input bit which, input logic [7:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        if (which) begin b1.cs = 1; b1.adr = a; b1.we = w; b1.dw = d; end
        else       begin b0.cs = 1; b0.adr = a; b0.we = w; b0.dw = d; end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_rd(input bit which, input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        if (which) begin b1.cs = 1; b1.adr = a; b1.re = 1; end
        else       begin b0.cs = 1; b0.adr = a; b0.re = 1; end
        @(negedge clk);
        d = which ? b1.dr : b0.dr;
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        bus_idle();

        // adr, we, dw, pout, poe, read-back
        vt[0]  = '{8'h00, 4'hF, 32'h000000A5, 16'h00A5, 16'h0000, 32'hA5};
        vt[1]  = '{8'h0C, 4'hF, 32'h0000000F, 16'h00AF, 16'h0000, 32'h00};
        vt[2]  = '{8'h10, 4'hF, 32'h00000081, 16'h002E, 16'h0000, 32'h00};
        vt[3]  = '{8'h08, 4'h1, 32'h123456FF, 16'h002E, 16'h00FF, 32'hFF};
        vt[4]  = '{8'h00, 4'h0, 32'h00000000, 16'h002E, 16'h00FF, 32'h2E};
        vt[5]  = '{8'h20, 4'h2, 32'h00005A77, 16'h002E, 16'h00FF, 32'h00};
        vt[6]  = '{8'h20, 4'h1, 32'hFFFFFF3C, 16'h3C2E, 16'h00FF, 32'h3C};
        vt[7]  = '{8'h00, 4'h2, 32'h0000FFFF, 16'h3C2E, 16'h00FF, 32'h2E};
        vt[8]  = '{8'h60, 4'hF, 32'h000000FF, 16'h3C2E, 16'h00FF, 32'h00};
        vt[9]  = '{8'h68, 4'hF, 32'h000000FF, 16'h3C2E, 16'h00FF, 32'h00};
        vt[10] = '{8'h28, 4'hF, 32'h0000000F, 16'h3C2E, 16'h0FFF, 32'h0F};
        vt[11] = '{8'h04, 4'hF, 32'h000000FF, 16'h3C2E, 16'h0FFF, 32'h00};
        vt[12] = '{8'h2C, 4'hF, 32'h000000C0, 16'hFC2E, 16'h0FFF, 32'h00};
        vt[13] = '{8'h30, 4'hF, 32'h0000000C, 16'hF02E, 16'h0FFF, 32'h00};
        vt[14] = '{8'h34, 4'hF, 32'h00000001, 16'hF02E, 16'h0FFF, 32'h01};
        vt[15] = '{8'h18, 4'hF, 32'h00000080, 16'hF02E, 16'h0FFF, 32'h80};
        vt[16] = '{8'h1C, 4'h0, 32'h00000000, 16'hF02E, 16'h0FFF, 32'h00};

        // Reset state
        repeat (2) @(negedge clk);
        xreset = 1;
        @(negedge clk);
        chk("rst_pout", 32'(pout0), 32'h0);
        chk("rst_poe",  32'(poe0),  32'h0);
        chk("rst_irq",  32'(irq0),  32'h0);
        chk("rst_dr",   b0.dr,      32'h0);
        for (int i = 0; i < 16; i++) begin
            bus_rd(0, 8'(((i / 8) << 5) | ((i % 8) << 2)), d);
            chk($sformatf("rst_rd%0d", i), d, 32'h0);
        end

        // Register access table
        for (int i = 0; i < 17; i++) begin
            if (vt[i].we != 4'h0) bus_wr(0, vt[i].adr, vt[i].we, vt[i].dw);
            chk($sformatf("vec%0d_pout", i), 32'(pout0), 32'(vt[i].exp_pout));
            chk($sformatf("vec%0d_poe", i),  32'(poe0),  32'(vt[i].exp_poe));
            bus_rd(0, vt[i].adr, d);
            chk($sformatf("vec%0d_rd", i), d, vt[i].exp_rd);
        end

        // Bank1 rising edge on pin[8], RISE_EN bank1 = 0x01
        @(negedge clk); pin0[8] = 1;
        @(negedge clk); chk("rise_irq_e0", 32'(irq0), 32'h0);
        @(negedge clk); chk("rise_irq_e1", 32'(irq0), 32'h0);
        b0.cs = 1; b0.re = 1; b0.adr = 8'h24;
        @(negedge clk);
        chk("rise_in_rd", b0.dr, 32'h01);
        chk("rise_irq_e2", 32'(irq0), 32'h1);
        bus_idle();
        bus_rd(0, 8'h3C, d); chk("rise_stat", d, 32'h01);
        bus_wr(0, 8'h3C, 4'hF, 32'h01);
        chk("rise_w1c_irq", 32'(irq0), 32'h0);

        // Bank0 falling edge on pin[7] colliding with a W1C of the same bit
        @(negedge clk); pin0[7] = 1;
        repeat (4) @(negedge clk);
        chk("fall_pre_irq", 32'(irq0), 32'h0);
        pin0[7] = 0;
        @(negedge clk);
        @(negedge clk);
        b0.cs = 1; b0.we = 4'hF; b0.adr = 8'h1C; b0.dw = 32'h80;
        @(negedge clk);
        bus_idle();
        chk("coll_irq", 32'(irq0), 32'h1);
        bus_wr(0, 8'h18, 4'hF, 32'h00);
        bus_rd(0, 8'h1C, d); chk("coll_stat_kept", d, 32'h80);
        bus_wr(0, 8'h1C, 4'hF, 32'h80);
        chk("coll_w1c_irq", 32'(irq0), 32'h0);

        // WIDTH=5 build: upper bits dropped, out-of-range bank ignored
        bus_wr(1, 8'h00, 4'hF, 32'hFFFFFFFF);
        chk("w5_pout", 32'(pout1), 32'h01F);
        bus_rd(1, 8'h00, d); chk("w5_rd", d, 32'h1F);
        bus_wr(1, 8'h60, 4'hF, 32'hFFFFFFFF);
        chk("w5_b3_pout", 32'(pout1), 32'h01F);
        bus_rd(1, 8'h60, d); chk("w5_b3_rd", d, 32'h0);

        // Asynchronous reset mid-pattern
        bus_wr(0, 8'h00, 4'hF, 32'hFF);
        chk("ar_pout_pre", 32'(pout0[7:0]), 32'hFF);
        pin0[8] = 0;
        repeat (4) @(negedge clk);
        pin0[8] = 1;
        repeat (4) @(negedge clk);
        chk("ar_irq_pre", 32'(irq0), 32'h1);
        #2 xreset = 0;
        #1;
        chk("ar_pout", 32'(pout0), 32'h0);
        chk("ar_poe",  32'(poe0),  32'h0);
        chk("ar_irq",  32'(irq0),  32'h0);
        @(negedge clk); xreset = 1;
        repeat (4) @(negedge clk);
        bus_rd(0, 8'h3C, d); chk("ar_stat_after", d, 32'h0);
        chk("ar_irq_after", 32'(irq0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
